// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
//
// Purpose : Shared definitions for the branch prediction / resolution slice.
//           Holds the conditional-branch type codes carried from decode and
//           the 2-bit PHT counter encoding used by the gshare predictor.
//
// Contents:
//   BR_BEQ..BR_BGEZ   3-bit branch type codes (000..101); 110/111 reserved.
//   phtState_t        2-bit saturating counter states of the PHT.
//   brTypeValid()     true for a defined (non-reserved) branch type code.
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    // Conditional branch type codes produced by the decoder.
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLEZ = 3'b010;
    localparam logic [2:0] BR_BGTZ = 3'b011;
    localparam logic [2:0] BR_BLTZ = 3'b100;
    localparam logic [2:0] BR_BGEZ = 3'b101;

    // PHT 2-bit saturating counter states, shared with the predictor.
    typedef enum logic [1:0] {
        PHT_STRONG_NT = 2'b00,
        PHT_WEAK_NT   = 2'b01,
        PHT_WEAK_T    = 2'b10,
        PHT_STRONG_T  = 2'b11
    } phtState_t;

    // Codes 110 and 111 are reserved and never resolve taken.
    function automatic logic brTypeValid(input logic [2:0] brType);
        return (brType <= BR_BGEZ);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_branch_cmp.sv
// -----------------------------------------------------------------------------
// branch_cmp
//
// Purpose : Purely combinational branch direction comparator. Given the branch
//           type and the two source operands it decides taken / not-taken.
//           Kept separate so an early-resolve path in D can reuse it.
//
// Ports:
//   brType  in  3   branch type code (see package BR_* constants)
//   a       in  32  rs operand
//   b       in  32  rt operand (only used by BEQ/BNE)
//   take    out 1   branch resolves taken
// -----------------------------------------------------------------------------
module branch_cmp
    import branch_resolve_unit_pkg::*;
(
    input  logic [2:0]  brType,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        take
);

    logic aIsZero;
    logic aIsNeg;
    logic aEqB;

    assign aIsZero = (a == 32'd0);
    assign aIsNeg  = a[31];
    assign aEqB    = (a == b);

    always_comb begin
        take = 1'b0;
        if (brTypeValid(brType)) begin
            case (brType)
                BR_BEQ:  take = aEqB;
                BR_BNE:  take = ~aEqB;
                BR_BLEZ: take = aIsNeg | aIsZero;
                BR_BGTZ: take = ~aIsNeg & ~aIsZero;
                BR_BLTZ: take = aIsNeg;
                BR_BGEZ: take = ~aIsNeg;
                default: take = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose : Resolution-side companion to the gshare predictor. Carries the
//           decode-stage prediction into E, resolves direction and target
//           there, and registers the verdict into M. From M it drives the
//           predictor training interface, the fetch redirect and two
//           saturating performance counters.
//
// Parameters:
//   PHT_DEPTH  PHT index width, also the retired history width (>= 2)
//   CNT_W      performance counter width
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   stallE, flushE           hold / bubble the D->E register
//   flushM                   bubble the E->M register
//   branchD, brtypeD, pcD,
//   immD, pred_takeD         decode-stage branch and its prediction
//   srcaE, srcbE             forwarded operands for the branch in E
//   branchM, actual_takeM,
//   pred_takeM               resolved branch in M
//   redirectM, redirect_pcM  mispredict pulse and the correct fetch PC
//   update_PHT_index,
//   ghr_real                 predictor training index and retired history
//   branch_cnt, mispred_cnt  saturating performance counters
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int PHT_DEPTH = 10,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallE,
    input  logic                 flushE,
    input  logic                 flushM,
    input  logic                 branchD,
    input  logic [2:0]           brtypeD,
    input  logic [31:0]          pcD,
    input  logic [31:0]          immD,
    input  logic                 pred_takeD,
    input  logic [31:0]          srcaE,
    input  logic [31:0]          srcbE,
    output logic                 branchM,
    output logic                 actual_takeM,
    output logic                 pred_takeM,
    output logic                 redirectM,
    output logic [31:0]          redirect_pcM,
    output logic [PHT_DEPTH-1:0] update_PHT_index,
    output logic [PHT_DEPTH-1:0] ghr_real,
    output logic [CNT_W-1:0]     branch_cnt,
    output logic [CNT_W-1:0]     mispred_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ---------------------------------------------------------------- D->E
    logic        branchE;
    logic [2:0]  brTypeE;
    logic [31:0] pcE;
    logic [31:0] immE;
    logic        predTakeE;

    always_ff @(posedge clk) begin
        if (!rst || flushE) begin
            branchE   <= 1'b0;
            brTypeE   <= 3'b000;
            pcE       <= 32'd0;
            immE      <= 32'd0;
            predTakeE <= 1'b0;
        end else if (!stallE) begin
            branchE   <= branchD;
            brTypeE   <= brtypeD;
            pcE       <= pcD;
            immE      <= immD;
            predTakeE <= pred_takeD;
        end
    end

    // ---------------------------------------------------------- E evaluate
    logic        actualTakeE;
    logic [31:0] targetE;
    logic [31:0] fallThroughE;
    logic [31:0] redirectPcE;

    branch_cmp uCmp (
        .brType (brTypeE),
        .a      (srcaE),
        .b      (srcbE),
        .take   (actualTakeE)
    );

    // Both adds wrap modulo 2^32; the fall-through skips the delay slot.
    assign targetE      = pcE + 32'd4 + (immE << 2);
    assign fallThroughE = pcE + 32'd8;
    assign redirectPcE  = actualTakeE ? targetE : fallThroughE;

    // ---------------------------------------------------------------- E->M
    // Only the PC bits that feed the PHT index are carried into M; the rest
    // of the PC has already been folded into redirect_pcM.
    logic [PHT_DEPTH-1:0] pcIdxM;

    always_ff @(posedge clk) begin
        if (!rst || flushM || !branchE) begin
            branchM      <= 1'b0;
            actual_takeM <= 1'b0;
            pred_takeM   <= 1'b0;
            redirect_pcM <= 32'd0;
            pcIdxM       <= '0;
        end else begin
            branchM      <= 1'b1;
            actual_takeM <= actualTakeE;
            pred_takeM   <= predTakeE;
            redirect_pcM <= redirectPcE;
            pcIdxM       <= pcE[PHT_DEPTH+1:2];
        end
    end

    // ------------------------------------------------------------ M outputs
    assign redirectM        = branchM & (actual_takeM ^ pred_takeM);
    // Index uses the history before this branch shifts into it.
    assign update_PHT_index = pcIdxM ^ ghr_real;

    // ------------------------------------------------------ retired history
    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr_real <= '0;
        end else if (branchM) begin
            ghr_real <= {ghr_real[PHT_DEPTH-2:0], actual_takeM};
        end
    end

    // ---------------------------------------------------- perf counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (branchM && (branch_cnt != CNT_MAX)) begin
                branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (redirectM && (mispred_cnt != CNT_MAX)) begin
                mispred_cnt <= mispred_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit (PHT_DEPTH=10, CNT_W=2 so counter
// saturation is reachable). Expected M-stage results are pushed to a
// scoreboard queue when a branch is in E and popped when it reaches M; a
// small model tracks history and counters.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int PHT_DEPTH = 10;
    localparam int CNT_W     = 2;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 stallE, flushE, flushM;
    logic                 branchD;
    logic [2:0]           brtypeD;
    logic [31:0]          pcD, immD;
    logic                 pred_takeD;
    logic [31:0]          srcaE, srcbE;
    logic                 branchM, actual_takeM, pred_takeM, redirectM;
    logic [31:0]          redirect_pcM;
    logic [PHT_DEPTH-1:0] update_PHT_index, ghr_real;
    logic [CNT_W-1:0]     branch_cnt, mispred_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.PHT_DEPTH(PHT_DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .stallE           (stallE),
        .flushE           (flushE),
        .flushM           (flushM),
        .branchD          (branchD),
        .brtypeD          (brtypeD),
        .pcD              (pcD),
        .immD             (immD),
        .pred_takeD       (pred_takeD),
        .srcaE            (srcaE),
        .srcbE            (srcbE),
        .branchM          (branchM),
        .actual_takeM     (actual_takeM),
        .pred_takeM       (pred_takeM),
        .redirectM        (redirectM),
        .redirect_pcM     (redirect_pcM),
        .update_PHT_index (update_PHT_index),
        .ghr_real         (ghr_real),
        .branch_cnt       (branch_cnt),
        .mispred_cnt      (mispred_cnt)
    );

    typedef struct packed {
        logic        actual;
        logic        pred;
        logic [31:0] rpc;
        logic [31:0] pc;
    } exp_t;

    exp_t scoreboard[$];

    int checks = 0;
    int errors = 0;

    // Branch held in the bench's view of D->E, awaiting its E operands.
    logic        pendValid;
    logic [2:0]  pendTy;
    logic [31:0] pendPc, pendImm, pendA, pendB;
    logic        pendPred;

    // Model of the state updated from M.
    logic [PHT_DEPTH-1:0] expGhr;
    logic [CNT_W-1:0]     expBr, expMis;
    logic                 prevValid, prevActual, prevMis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic refTake(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] b);
        case (ty)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) <= 0;
            3'd3:    return $signed(a) > 0;
            3'd4:    return $signed(a) < 0;
            3'd5:    return $signed(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive D inputs (a new branch) and E operands (for the branch
    // already in E), then check M one edge later.
    task automatic drive(input logic br, input logic [2:0] ty, input logic [31:0] pc,
                         input logic [31:0] imm, input logic pred,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic stall, input logic fM);
        exp_t e;
        logic pushed;
        pushed  = 1'b0;
        srcaE   = pendA;
        srcbE   = pendB;
        stallE  = stall;
        flushM  = fM;
        branchD = br;
        brtypeD = ty;
        pcD     = pc;
        immD    = imm;
        pred_takeD = pred;
        if (pendValid && !fM) begin
            e.actual = refTake(pendTy, pendA, pendB);
            e.pred   = pendPred;
            e.pc     = pendPc;
            e.rpc    = e.actual ? (pendPc + 32'd4 + {pendImm[29:0], 2'b00}) : (pendPc + 32'd8);
            scoreboard.push_back(e);
            pushed = 1'b1;
        end
        if (!stall) begin
            pendValid = br;
            pendTy    = ty;
            pendPc    = pc;
            pendImm   = imm;
            pendPred  = pred;
            pendA     = a;
            pendB     = b;
        end
        @(posedge clk);
        #1;
        // State written by the branch that was in M before this edge.
        if (prevValid) begin
            expGhr = {expGhr[PHT_DEPTH-2:0], prevActual};
            if (expBr != CMAX) expBr = expBr + 1'b1;
            if (prevMis && expMis != CMAX) expMis = expMis + 1'b1;
        end
        chk("ghr_real", 32'(ghr_real), 32'(expGhr));
        chk("branch_cnt", 32'(branch_cnt), 32'(expBr));
        chk("mispred_cnt", 32'(mispred_cnt), 32'(expMis));
        if (pushed) begin
            e = scoreboard.pop_front();
            chk("branchM", 32'(branchM), 32'd1);
            chk("actual_takeM", 32'(actual_takeM), 32'(e.actual));
            chk("pred_takeM", 32'(pred_takeM), 32'(e.pred));
            chk("redirectM", 32'(redirectM), 32'(e.actual != e.pred));
            chk("redirect_pcM", redirect_pcM, e.rpc);
            chk("update_PHT_index", 32'(update_PHT_index), 32'(e.pc[PHT_DEPTH+1:2] ^ expGhr));
            $display("M: pc=0x%08h take=%0d pred=%0d rpc=0x%08h idx=0x%03h ghr=0x%03h",
                     e.pc, actual_takeM, pred_takeM, redirect_pcM, update_PHT_index, ghr_real);
            prevValid  = 1'b1;
            prevActual = e.actual;
            prevMis    = (e.actual != e.pred);
        end else begin
            chk("branchM_idle", 32'(branchM), 32'd0);
            chk("redirectM_idle", 32'(redirectM), 32'd0);
            prevValid = 1'b0;
        end
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b0;
        stallE = 1'b0; flushE = 1'b0; flushM = 1'b0;
        branchD = 1'b0; brtypeD = 3'd0; pcD = 32'd0; immD = 32'd0; pred_takeD = 1'b0;
        srcaE = 32'd0; srcbE = 32'd0;
        @(posedge clk);
        #1;
        chk("rst_branchM", 32'(branchM), 32'd0);
        chk("rst_actual", 32'(actual_takeM), 32'd0);
        chk("rst_pred", 32'(pred_takeM), 32'd0);
        chk("rst_redirect", 32'(redirectM), 32'd0);
        chk("rst_rpc", redirect_pcM, 32'd0);
        chk("rst_idx", 32'(update_PHT_index), 32'd0);
        chk("rst_ghr", 32'(ghr_real), 32'd0);
        chk("rst_bcnt", 32'(branch_cnt), 32'd0);
        chk("rst_mcnt", 32'(mispred_cnt), 32'd0);
        $display("RESET: all outputs checked for zero");
        scoreboard.delete();
        pendValid = 1'b0; pendTy = 3'd0; pendPc = 32'd0; pendImm = 32'd0;
        pendPred = 1'b0; pendA = 32'd0; pendB = 32'd0;
        expGhr = '0; expBr = '0; expMis = '0;
        prevValid = 1'b0; prevActual = 1'b0; prevMis = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        doReset();

        // BEQ taken, predicted not-taken: mispredict to 0x00400020.
        drive(1'b1, 3'd0, 32'h0040_0010, 32'h3, 1'b0, 32'd5, 32'd5, 1'b0, 1'b0);
        idle();
        chk("beq_rpc", redirect_pcM, 32'h0040_0020);
        chk("beq_redirect", 32'(redirectM), 32'd1);
        idle();
        chk("beq_ghr", 32'(ghr_real), 32'h001);
        chk("beq_mcnt", 32'(mispred_cnt), 32'd1);

        // BNE with a==b: not taken, correctly predicted.
        drive(1'b1, 3'd1, 32'h0000_0100, 32'h10, 1'b0, 32'd7, 32'd7, 1'b0, 1'b0);
        idle();
        chk("bne_redirect", 32'(redirectM), 32'd0);
        chk("bne_rpc", redirect_pcM, 32'h0000_0108);
        idle();
        chk("bne_ghr", 32'(ghr_real), 32'h002);

        // BLTZ with negative a: taken, target wraps.
        drive(1'b1, 3'd4, 32'h0, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        idle();
        chk("bltz_rpc", redirect_pcM, 32'hFFFF_FFFC);
        idle();

        // Remaining types and a reserved code, back to back.
        drive(1'b1, 3'd2, 32'h200, 32'h1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 3'd3, 32'h204, 32'h2, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 32'h208, 32'h3, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 3'd6, 32'h20C, 32'h4, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 3'd3, 32'h210, 32'h5, 1'b0, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0);
        idle();
        idle();

        // Branch in E together with flushM: dropped, nothing updates.
        drive(1'b1, 3'd0, 32'h300, 32'h1, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("flushM_branchM", 32'(branchM), 32'd0);
        idle();
        idle();

        // Stall with flushM: the branch waits in E, D inputs are ignored.
        drive(1'b1, 3'd1, 32'h400, 32'h8, 1'b0, 32'd1, 32'd2, 1'b0, 1'b0);
        drive(1'b1, 3'd0, 32'h500, 32'h9, 1'b1, 32'd3, 32'd3, 1'b1, 1'b1);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("stall_rpc", redirect_pcM, 32'h0000_0424);
        idle();
        idle();

        // Preload ghr to all ones, then index for pc 0xFFC must be zero.
        doReset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd0, 32'h1000 + 32'(i * 4), 32'h1, 1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
        end
        drive(1'b1, 3'd0, 32'h0000_0FFC, 32'h1, 1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
        idle();
        chk("preload_ghr", 32'(ghr_real), 32'h3FF);
        chk("preload_idx", 32'(update_PHT_index), 32'h000);
        idle();

        // Five mispredicts saturate the 2-bit counters.
        doReset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd0, 32'h2000 + 32'(i * 4), 32'h2, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
        end
        idle();
        idle();
        chk("sat_mcnt", 32'(mispred_cnt), 32'd3);
        chk("sat_bcnt", 32'(branch_cnt), 32'd3);

        // Reset with branches in E and M: discarded, no updates afterwards.
        drive(1'b1, 3'd0, 32'h3000, 32'h1, 1'b0, 32'd4, 32'd4, 1'b0, 1'b0);
        drive(1'b1, 3'd1, 32'h3004, 32'h1, 1'b0, 32'd4, 32'd5, 1'b0, 1'b0);
        doReset();
        idle();
        idle();

        if (scoreboard.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", scoreboard.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolution-side companion to the global-history (gshare) predictor. It carries the decode-stage prediction down the pipeline, evaluates the real branch outcome and target in E, and registers the verdict into M. From M it drives the predictor's training interface (update enable, PHT index, actual direction, retired history), the fetch redirect on a mispredict, and two saturating performance counters.

## Interface
Parameters:
- PHT_DEPTH, 10: PHT index width; also the retired global history width.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: synchronous reset, active-low (asserted when 0).
- stallE  in  1: hold the D→E register.
- flushE  in  1: clear the D→E register (load a bubble).
- flushM  in  1: clear the E→M register (load a bubble).
- branchD  in  1: D-stage instruction is a conditional branch.
- brtypeD  in  3: branch type code (package constants).
- pcD  in  32: branch PC.
- immD  in  32: sign-extended word offset.
- pred_takeD  in  1: predictor direction for the D-stage branch.
- srcaE  in  32: forwarded rs value in E.
- srcbE  in  32: forwarded rt value in E.
- branchM  out  1: valid branch in M.
- actual_takeM  out  1: resolved direction.
- pred_takeM  out  1: prediction carried along to M.
- redirectM  out  1: branchM & (actual_takeM != pred_takeM).
- redirect_pcM  out  32: correct fetch PC when redirectM is high.
- update_PHT_index  out  PHT_DEPTH: pcM[PHT_DEPTH+1:2] ^ ghr_real.
- ghr_real  out  PHT_DEPTH: retired global history.
- branch_cnt  out  CNT_W: resolved branches, saturating.
- mispred_cnt  out  CNT_W: mispredicts, saturating.

## Operation
- **D→E register** holds branch, brtype, pc, imm and pred_take.
  - Priority: reset > flushE (load zeros) > ~stallE (load) > hold.
- **E evaluation (combinational).**
  - Direction by type:
    - BEQ: a==b.
    - BNE: a!=b.
    - BLEZ: a ≤ 0 (signed).
    - BGTZ: a > 0 (signed).
    - BLTZ: a < 0 (signed).
    - BGEZ: a ≥ 0 (signed).
    - Codes 110/111 are reserved and resolve not-taken.
  - Taken target = pcE + 4 + (immE << 2), modulo 2^32 (wrap is allowed).
  - Fall-through = pcE + 8 (MIPS delay slot), modulo 2^32.
- **E→M register** holds branch, actual_take, pred_take, pc and redirect_pc.
  - redirect_pc = actual ? target : fall-through.
  - Loads every cycle; flushM loads zeros.
  - A bubble in E (branchE=0) also forces all fields to zero.
- **M outputs.**
  - All M outputs come directly from the E→M register, except redirectM and update_PHT_index, which are combinational from that register and ghr_real.
- **Retired history.**
  - On branchM: ghr_real <= {ghr_real[PHT_DEPTH-2:0], actual_takeM}.
  - update_PHT_index always uses the pre-shift value.
- **Counters.**
  - branch_cnt increments on branchM.
  - mispred_cnt increments on redirectM.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (rst=0 at a clock edge) zeroes every register.
  - Consequently every output reads 0, including redirect_pcM and both counters.
  - A reset during an in-flight branch discards it: no redirect and no history or counter update.
- Latency from branchD to branchM is two edges when no stalls occur. A stall in E adds one cycle per stalled cycle.
- The same branch is never counted twice:
  - While stallE holds a branch in D→E, E→M still loads every cycle.
  - Therefore stallE must be accompanied by flushM from the hazard unit; this is the integration rule.
- redirectM is a one-cycle pulse per mispredicted branch. The hazard unit converts it into flushD/flushE.
- flushM and a resolving branch in E in the same cycle: the branch is dropped with no side effects.
- branchM on consecutive cycles: history shifts each cycle, and each index uses the history produced by the previous branch.

## Structure
- Shared package holds:
  - The BR_BEQ..BR_BGEZ codes (000..101).
  - The 2-bit PHT state constants already used by the predictor.
- One sub-module, branch_cmp: a purely combinational (brtype, a, b) → take comparator, reusable by a future D-stage early-resolve path.
- Both pipeline registers, the history register and the counters live in branch_resolve_unit. Estimated size is about 200 lines.

## Test plan
- BEQ at pcD=0x00400010, imm=0x3, a=b=5, pred_takeD=0 → two edges later:
  - branchM=1, actual_takeM=1, redirectM=1, redirect_pcM=0x00400020.
  - mispred_cnt=1, and ghr_real becomes 0x001 after the edge.
- BNE with a=b, pred=0 at pc=0x100 → redirectM=0, branch_cnt=1, ghr_real shifts in 0.
- BLTZ with a=0xFFFFFFFF and imm=0xFFFFFFFE at pc=0x0 → taken, redirect_pcM=0xFFFFFFFC (wrap).
- Branch in E together with flushM=1 → branchM=0, counters and ghr_real unchanged.
- Preload ghr_real=0x3FF, then a branch at pc=0x00000FFC → update_PHT_index=0x3FF^0x3FF=0x000.
- Counter saturation with CNT_W=2: five mispredicted branches → mispred_cnt=3. Then rst=0 mid-flight → all outputs 0 on the next edge.
